// File: rtl/demux2_if.sv
// Link bundle between the time-multiplexed sender side and the demux2 receiver.
// state_dbg exposes the receiver FSM state so checkers can bind to it.
interface demux2_if;
  logic [3:0] din;
  logic       sel_in;
  logic [3:0] dout0;
  logic [3:0] dout1;
  logic       upd0;
  logic       upd1;
  logic       link_ok;
  logic       glitch;
  logic [7:0] glitch_cnt;
  logic [1:0] state_dbg;

  modport master (
    output din, sel_in,
    input  dout0, dout1, upd0, upd1, link_ok, glitch, glitch_cnt, state_dbg
  );

  modport slave (
    input  din, sel_in,
    output dout0, dout1, upd0, upd1, link_ok, glitch, glitch_cnt, state_dbg
  );
endinterface

// File: rtl/demux2.sv
// Receive side of the 4-bit time-multiplexed link: synchronises the phase line,
// waits for the bus to settle, captures per phase, flags glitches, watches for a dead link.
module demux2 #(
  parameter int SETTLE = 4,
  parameter int TW     = 26
) (
  input  logic      clk,
  input  logic      rstn,
  demux2_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [7:0]    SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [TW-1:0] WD_ONE    = TW'(1);
  localparam logic [TW-1:0] WD_MAX    = '1;
  localparam logic [TW-1:0] WD_NEAR   = WD_MAX - WD_ONE;

  logic          r_s1, r_s2, r_s3;
  state_t        r_state;
  logic [7:0]    r_cnt;
  logic          r_phase;
  logic [TW-1:0] r_wd;
  logic [3:0]    r_dout0, r_dout1;
  logic          r_upd0, r_upd1;
  logic          r_link;
  logic          r_glitch;
  logic [7:0]    r_gcnt;

  state_t        w_state_next;
  logic [7:0]    w_cnt_next;
  logic          w_phase_next;
  logic          w_link_next;
  logic          w_cap0, w_cap1;
  logic          w_glitch;
  logic          w_edge;
  logic          w_wd_expire;
  logic [3:0]    w_cur;

  assign w_edge      = r_s2 ^ r_s3;
  assign w_wd_expire = !w_edge && (r_wd == WD_NEAR);
  assign w_cur       = r_phase ? r_dout1 : r_dout0;

  // Priority: phase edge, then watchdog expiry, then the normal state action.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_phase_next = r_phase;
    w_link_next  = r_link;
    w_cap0       = 1'b0;
    w_cap1       = 1'b0;
    w_glitch     = 1'b0;
    if (w_edge) begin
      w_state_next = ST_SETTLE;
      w_cnt_next   = SETTLE_M1;
      w_phase_next = r_s2;
    end else if (w_wd_expire) begin
      w_state_next = ST_IDLE;
      w_link_next  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_SETTLE: begin
          if (r_cnt == 8'd0) begin
            w_cap0       = !r_phase;
            w_cap1       = r_phase;
            w_link_next  = 1'b1;
            w_state_next = ST_HOLD;
          end else begin
            w_cnt_next = r_cnt - 8'd1;
          end
        end
        ST_HOLD: w_glitch = (bus.din != w_cur);
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_phase  <= 1'b0;
      r_wd     <= '0;
      r_dout0  <= 4'd0;
      r_dout1  <= 4'd0;
      r_upd0   <= 1'b0;
      r_upd1   <= 1'b0;
      r_link   <= 1'b0;
      r_glitch <= 1'b0;
      r_gcnt   <= 8'd0;
    end else begin
      r_s1     <= bus.sel_in;
      r_s2     <= r_s1;
      r_s3     <= r_s2;
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_phase  <= w_phase_next;
      r_link   <= w_link_next;
      r_upd0   <= w_cap0;
      r_upd1   <= w_cap1;
      r_glitch <= w_glitch;
      if (w_cap0) r_dout0 <= bus.din;
      if (w_cap1) r_dout1 <= bus.din;
      if (w_glitch && (r_gcnt != 8'hFF)) r_gcnt <= r_gcnt + 8'd1;
      if (w_edge) r_wd <= '0;
      else if (r_wd != WD_MAX) r_wd <= r_wd + WD_ONE;
    end
  end

  assign bus.dout0      = r_dout0;
  assign bus.dout1      = r_dout1;
  assign bus.upd0       = r_upd0;
  assign bus.upd1       = r_upd1;
  assign bus.link_ok    = r_link;
  assign bus.glitch     = r_glitch;
  assign bus.glitch_cnt = r_gcnt;
  assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_demux2.sv
// Bench for demux2: directed vector table, mid-settle reset sequence and random
// phase/data traffic, every cycle compared against a history-based reference.
module tb_demux2;
  localparam int ST  = 3;
  localparam int TWB = 6;
  localparam int WDM = (1 << TWB) - 1;
  localparam int W   = 20;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  demux2_if bus();

  demux2 #(.SETTLE(ST), .TW(TWB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Reference: outcome derived from the sel_in history seen since reset.
  logic       sel_h[$];
  int         c;
  int         last_edge;
  bit         edge_seen;
  logic [3:0] m_d0, m_d1;
  logic       m_link;
  logic [7:0] m_gcnt;

  typedef struct {
    logic [3:0] din;
    logic       sel;
    int         n;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       u0;
    logic       u1;
    logic       lk;
    logic       g;
    logic [7:0] gc;
  } vec_t;

  function automatic logic sel_at(input int i);
    return (i >= 1) ? sel_h[i-1] : 1'b0;
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {bus.dout0, bus.dout1, bus.upd0, bus.upd1, bus.link_ok, bus.glitch, bus.glitch_cnt};
  endfunction

  task automatic model_reset();
    sel_h.delete();
    exp_q.delete();
    c         = 0;
    last_edge = 0;
    edge_seen = 0;
    m_d0      = 4'd0;
    m_d1      = 4'd0;
    m_link    = 1'b0;
    m_gcnt    = 8'd0;
  endtask

  // A value registered at edge k is seen as a phase change at edge k+2.
  task automatic model_step(input logic [3:0] d, input logic s);
    logic       u0, u1, g;
    logic [3:0] cur;
    u0 = 1'b0;
    u1 = 1'b0;
    g  = 1'b0;
    c++;
    sel_h.push_back(s);
    if (sel_at(c-2) != sel_at(c-3)) begin
      last_edge = c;
      edge_seen = 1'b1;
    end else if (c - last_edge == WDM) begin
      m_link = 1'b0;
    end
    if (edge_seen && (c == last_edge + ST)) begin
      if (sel_at(last_edge-2)) begin m_d1 = d; u1 = 1'b1; end
      else begin m_d0 = d; u0 = 1'b1; end
      m_link = 1'b1;
    end else if (edge_seen && (c > last_edge + ST) && (c - last_edge < WDM)) begin
      cur = sel_at(last_edge-2) ? m_d1 : m_d0;
      if (d != cur) begin
        g = 1'b1;
        if (m_gcnt != 8'hFF) m_gcnt++;
      end
    end
    exp_q.push_back({m_d0, m_d1, u0, u1, m_link, g, m_gcnt});
  endtask

  task automatic tick(input logic [3:0] d, input logic s);
    logic [W-1:0] e, a;
    bus.din    = d;
    bus.sel_in = s;
    @(posedge clk);
    model_step(d, s);
    #1;
    e = exp_q.pop_front();
    a = dut_vec();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL cycle %0d: got %h expected %h", c, a, e);
    end
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] e);
    logic [W-1:0] a;
    a = dut_vec();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  initial begin
    vec_t       tbl[$];
    logic       s_r;
    logic [3:0] base;
    logic [3:0] d;
    int         len;

    tbl.push_back('{4'hA, 1'b0,  9, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{4'h5, 1'b1,  6, 4'h0, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'h5, 1'b1,  1, 4'h0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'h7, 1'b1,  1, 4'h0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1});
    tbl.push_back('{4'h7, 1'b1,  1, 4'h0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2});
    tbl.push_back('{4'h5, 1'b1,  1, 4'h0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2});
    tbl.push_back('{4'h5, 1'b0,  2, 4'h0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2});
    tbl.push_back('{4'hA, 1'b0,  4, 4'hA, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2});
    tbl.push_back('{4'hA, 1'b1,  2, 4'hA, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2});
    tbl.push_back('{4'hB, 1'b0,  5, 4'hA, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2});
    tbl.push_back('{4'hB, 1'b0,  1, 4'hB, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2});
    tbl.push_back('{4'hB, 1'b0, 59, 4'hB, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2});
    tbl.push_back('{4'hB, 1'b0,  1, 4'hB, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2});
    tbl.push_back('{4'h6, 1'b1,  6, 4'hB, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2});

    // Clock/reset
    bus.din    = 4'hA;
    bus.sel_in = 1'b0;
    rstn       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset", '0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();

    // Directed table
    for (int r = 0; r < tbl.size(); r++) begin
      for (int i = 0; i < tbl[r].n; i++) tick(tbl[r].din, tbl[r].sel);
      check_vec($sformatf("row%0d", r),
                {tbl[r].d0, tbl[r].d1, tbl[r].u0, tbl[r].u1, tbl[r].lk, tbl[r].g, tbl[r].gc});
    end

    // Reset while in SETTLE, then release with sel_in high
    repeat (3) tick(4'h9, 1'b0);
    bus.sel_in = 1'b1;
    rstn       = 1'b0;
    #1;
    check_vec("reset_mid_settle", '0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_vec("held_in_reset", '0);
    end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    repeat (6) tick(4'h9, 1'b1);
    check_vec("capture_after_release", {4'h0, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});

    // Random phases: short segments abort captures, long ones trip the watchdog
    s_r = 1'b1;
    for (int seg = 0; seg < 60; seg++) begin
      s_r  = ~s_r;
      base = 4'($urandom_range(0, 15));
      len  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 80));
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : base;
        tick(d, s_r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
